// File: rtl/num_node_reader.sv
// Streams per-subgraph node counts out of the num_node BRAM port B in address order through a credit-guarded FWFT FIFO.
// Issue-to-valid latency BRAM_LAT+1; reads pause when the writer has not committed an address or when FIFO credit runs out.
`timescale 1ns/1ps
module num_node_reader #(
    parameter int NUM_NODE_WIDTH  = 8,
    parameter int NUM_SUBGRAPHS   = 2708,
    parameter int NUM_NODE_ADDR_W = 12,
    parameter int BRAM_LAT        = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [NUM_NODE_ADDR_W:0]   wr_cnt_i,
    output logic                       num_node_bram_enb,
    output logic [NUM_NODE_ADDR_W-1:0] num_node_bram_addrb,
    input  logic [NUM_NODE_WIDTH-1:0]  num_node_bram_doutb,
    output logic [NUM_NODE_WIDTH-1:0]  num_node_o,
    output logic                       num_node_vld_o,
    input  logic                       num_node_rdy_i,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int AW1   = NUM_NODE_ADDR_W + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW1-1:0]   TOTAL     = AW1'(NUM_SUBGRAPHS);
    localparam logic [AW1-1:0]   LAST_ADDR = AW1'(NUM_SUBGRAPHS - 1);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [AW1-1:0]              r_rd_addr;
    logic [AW1-1:0]              r_delivered;
    logic [NUM_NODE_ADDR_W-1:0]  r_addrb;
    logic [CNT_W-1:0]            r_in_flight;
    logic [CNT_W-1:0]            r_fifo_cnt;
    logic [BRAM_LAT-1:0]         r_lat_sr;
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [NUM_NODE_WIDTH-1:0]   r_mem [FIFO_DEPTH];

    logic                        w_credit_ok;
    logic                        w_issue;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_vld;
    logic [BRAM_LAT-1:0]         w_sr_nxt;
    logic [AW1-1:0]              w_delivered_nxt;

    // Credit covers both reads still inside the BRAM pipe and entries already buffered.
    assign w_credit_ok = ({1'b0, r_in_flight} + {1'b0, r_fifo_cnt}) < DEPTH_C;
    assign w_issue     = (r_state == S_FETCH) && (r_rd_addr < wr_cnt_i) &&
                         (r_rd_addr < TOTAL) && w_credit_ok;
    assign w_push      = r_lat_sr[BRAM_LAT-1];
    assign w_vld       = (r_fifo_cnt != '0);
    assign w_pop       = w_vld && num_node_rdy_i;
    assign w_delivered_nxt = w_pop ? (r_delivered + AW1'(1)) : r_delivered;

    generate
        if (BRAM_LAT == 1) begin : g_sr1
            assign w_sr_nxt = w_issue;
        end else begin : g_srn
            assign w_sr_nxt = {r_lat_sr[BRAM_LAT-2:0], w_issue};
        end
    endgenerate

    assign num_node_bram_enb   = w_issue;
    assign num_node_bram_addrb = w_issue ? r_rd_addr[NUM_NODE_ADDR_W-1:0] : r_addrb;
    assign num_node_o          = r_mem[r_rd_ptr];
    assign num_node_vld_o      = w_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (w_issue && (r_rd_addr == LAST_ADDR)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_delivered_nxt == TOTAL) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr   <= '0;
            r_delivered <= '0;
            r_addrb     <= '0;
            r_in_flight <= '0;
            r_lat_sr    <= '0;
        end else begin
            if ((r_state == S_IDLE) && start_i) begin
                r_rd_addr   <= '0;
                r_delivered <= '0;
            end else begin
                if (w_issue) r_rd_addr <= r_rd_addr + AW1'(1);
                r_delivered <= w_delivered_nxt;
            end
            if (w_issue) r_addrb <= r_rd_addr[NUM_NODE_ADDR_W-1:0];
            r_lat_sr <= w_sr_nxt;
            case ({w_issue, w_push})
                2'b10:   r_in_flight <= r_in_flight + CNT_W'(1);
                2'b01:   r_in_flight <= r_in_flight - CNT_W'(1);
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= num_node_bram_doutb;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_num_node_reader.sv
// Bench for num_node_reader: three instances (BRAM_LAT 2/1/4) each with a BRAM model and an in-order scoreboard.
`timescale 1ns/1ps
module tb_num_node_reader;

    localparam int NW   = 8;
    localparam int NS   = 2708;
    localparam int AW   = 12;
    localparam int MAXN = 168;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_a  [3];
    logic [AW:0]   wr_cnt_a [3];
    logic          rdy_a    [3];
    int            rdy_pct  [3];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc   = 0;
    bit            throttle = 1'b0;
    int            tdiv     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    generate
        for (genvar g = 0; g < 3; g++) begin : gen_dut
            localparam int LAT = (g == 1) ? 1 : (g == 2) ? 4 : 2;
            localparam int DEP = (g == 2) ? 8 : 4;

            logic          enb;
            logic [AW-1:0] addrb;
            logic [NW-1:0] doutb;
            logic [NW-1:0] num_node;
            logic          vld;
            logic          busy;
            logic          done;
            logic [NW-1:0] pipe [LAT];

            num_node_reader #(
                .NUM_NODE_WIDTH(NW), .NUM_SUBGRAPHS(NS), .NUM_NODE_ADDR_W(AW),
                .BRAM_LAT(LAT), .FIFO_DEPTH(DEP)
            ) u_dut (
                .clk(clk), .rst_n(rst_n), .start_i(start_a[g]), .wr_cnt_i(wr_cnt_a[g]),
                .num_node_bram_enb(enb), .num_node_bram_addrb(addrb),
                .num_node_bram_doutb(doutb), .num_node_o(num_node),
                .num_node_vld_o(vld), .num_node_rdy_i(rdy_a[g]),
                .busy_o(busy), .done_o(done)
            );

            // BRAM content is addr mod 168; 0xEE marks cycles with no read so mistimed sampling shows up.
            always @(posedge clk) begin
                pipe[0] <= enb ? NW'(int'(addrb) % MAXN) : 8'hEE;
                for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            end
            assign doutb = pipe[LAT-1];

            int       sbq [$];
            int       exp_addr = 0, n_issued = 0, n_deliv = 0, n_done = 0, occ = 0;
            int       first_enb = -1, first_vld = -1, last_xfer = -1, done_cyc = -1, busy_fall = -1;
            int       sb_left = 0;
            bit       seen_pp1 = 0, seen_pp4 = 0, prev_busy = 0;
            logic [7:0] hist = '0;

            always @(negedge clk) begin : mon
                bit push, pop;
                if (!rst_n) begin
                    sbq.delete();
                    exp_addr = 0; n_issued = 0; n_deliv = 0; n_done = 0; occ = 0;
                    first_enb = -1; first_vld = -1; last_xfer = -1; done_cyc = -1; busy_fall = -1;
                    hist = '0; prev_busy = 0; sb_left = 0;
                end else begin
                    if (start_a[g] && !busy) begin
                        sbq.delete();
                        exp_addr = 0; n_issued = 0; n_deliv = 0; n_done = 0; occ = 0;
                        first_enb = -1; first_vld = -1; last_xfer = -1; done_cyc = -1; busy_fall = -1;
                    end
                    push = hist[LAT-1];
                    pop  = vld && rdy_a[g];
                    chk($sformatf("vld_vs_occ[%0d]", g), vld, (occ != 0));
                    if (enb) begin
                        chk($sformatf("issue_addr[%0d]", g), addrb, exp_addr);
                        chk($sformatf("issue_committed[%0d]", g), (addrb < wr_cnt_a[g]), 1);
                        sbq.push_back(exp_addr % MAXN);
                        exp_addr++;
                        n_issued++;
                        if (first_enb < 0) first_enb = cyc;
                    end
                    if (vld && first_vld < 0) first_vld = cyc;
                    if (pop) begin
                        if (sbq.size() == 0) chk($sformatf("sb_extra[%0d]", g), num_node, -1);
                        else chk($sformatf("data[%0d]", g), num_node, sbq.pop_front());
                        n_deliv++;
                        last_xfer = cyc;
                    end
                    if (push && pop && occ == 1) seen_pp1 = 1;
                    if (push && pop && occ == 4) seen_pp4 = 1;
                    if (push) chk($sformatf("no_overflow[%0d]", g), (occ + 1 - int'(pop) <= DEP), 1);
                    if (done) begin
                        n_done++;
                        done_cyc = cyc;
                    end
                    if (prev_busy && !busy) busy_fall = cyc;
                    prev_busy = busy;
                    occ  = occ + int'(push) - int'(pop);
                    hist = {hist[6:0], enb};
                    sb_left = sbq.size();
                end
            end
        end
    endgenerate

    task automatic step();
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) rdy_a[g] = ($urandom_range(0, 99) < rdy_pct[g]);
        if (throttle) begin
            tdiv++;
            if (tdiv == 5) begin
                tdiv = 0;
                if (wr_cnt_a[0] < NS) wr_cnt_a[0] = wr_cnt_a[0] + 1'b1;
            end
        end
    endtask

    task automatic wait_idle0(input int budget);
        int k = 0;
        while (!(gen_dut[0].n_done > 0 && !gen_dut[0].busy) && k < budget) begin
            step();
            k++;
        end
        chk("run0_completes", (k < budget), 1);
    endtask

    typedef struct {
        string name;
        bit    thr;
        int    hold;
        int    pct;
        int    exp_xfers;
        int    exp_done;
        int    exp_lat;
    } vec_t;

    initial begin
        vec_t tbl [4];
        int   d0, k;

        tbl[0] = '{name: "full",     thr: 0, hold: 0,  pct: 100, exp_xfers: NS, exp_done: 1, exp_lat: 3};
        tbl[1] = '{name: "throttle", thr: 1, hold: 0,  pct: 100, exp_xfers: NS, exp_done: 1, exp_lat: 3};
        tbl[2] = '{name: "backpres", thr: 0, hold: 20, pct: 100, exp_xfers: NS, exp_done: 1, exp_lat: 3};
        tbl[3] = '{name: "rand_rdy", thr: 0, hold: 0,  pct: 50,  exp_xfers: NS, exp_done: 1, exp_lat: 3};

        for (int g = 0; g < 3; g++) begin
            start_a[g] = 1'b0; wr_cnt_a[g] = '0; rdy_a[g] = 1'b0; rdy_pct[g] = 0;
        end
        #2;
        chk("rst_enb",   gen_dut[0].enb, 0);
        chk("rst_addrb", gen_dut[0].addrb, 0);
        chk("rst_vld",   gen_dut[0].vld, 0);
        chk("rst_data",  gen_dut[0].num_node, 0);
        chk("rst_busy",  gen_dut[0].busy, 0);
        chk("rst_done",  gen_dut[0].done, 0);
        step(); step();
        rst_n = 1'b1;
        step(); step();

        for (int t = 0; t < 4; t++) begin
            throttle    = tbl[t].thr;
            tdiv        = 0;
            wr_cnt_a[0] = tbl[t].thr ? '0 : (AW+1)'(NS);
            rdy_pct[0]  = (tbl[t].hold > 0) ? 0 : tbl[t].pct;
            rdy_a[0]    = (rdy_pct[0] == 100);
            start_a[0]  = 1'b1;
            step();
            start_a[0]  = 1'b0;
            if (tbl[t].hold > 0) begin
                repeat (tbl[t].hold) step();
                chk("bp_issued",   gen_dut[0].n_issued, 4);
                chk("bp_deliv",    gen_dut[0].n_deliv, 0);
                chk("bp_occ",      gen_dut[0].occ, 4);
                chk("bp_vld",      gen_dut[0].vld, 1);
                chk("bp_head",     gen_dut[0].num_node, 0);
                rdy_pct[0] = tbl[t].pct;
                step();
                d0 = gen_dut[0].n_deliv;
                for (int c = 0; c < 40; c++) begin
                    step();
                    chk("bp_stream_vld", gen_dut[0].vld, 1);
                end
                chk("bp_rate", gen_dut[0].n_deliv - d0, 40);
            end
            wait_idle0(6 * NS);
            repeat (5) step();
            chk($sformatf("%s_xfers", tbl[t].name), gen_dut[0].n_deliv, tbl[t].exp_xfers);
            chk($sformatf("%s_done_cnt", tbl[t].name), gen_dut[0].n_done, tbl[t].exp_done);
            chk($sformatf("%s_first_lat", tbl[t].name), gen_dut[0].first_vld - gen_dut[0].first_enb, tbl[t].exp_lat);
            chk($sformatf("%s_sb_empty", tbl[t].name), gen_dut[0].sb_left, 0);
            chk($sformatf("%s_done_after_last", tbl[t].name), gen_dut[0].done_cyc - gen_dut[0].last_xfer, 1);
            chk($sformatf("%s_busy_fall", tbl[t].name), gen_dut[0].busy_fall - gen_dut[0].done_cyc, 1);
        end
        throttle = 1'b0;
        chk("pp_occ1_seen", gen_dut[0].seen_pp1, 1);

        // BRAM_LAT 1 and 4 instances under random backpressure, run side by side.
        for (int g = 1; g < 3; g++) begin
            wr_cnt_a[g] = (AW+1)'(NS);
            rdy_pct[g]  = 50;
            start_a[g]  = 1'b1;
        end
        step();
        start_a[1] = 1'b0;
        start_a[2] = 1'b0;
        k = 0;
        while (!(gen_dut[1].n_done > 0 && !gen_dut[1].busy && gen_dut[2].n_done > 0 && !gen_dut[2].busy)
               && k < 6 * NS) begin
            step();
            k++;
        end
        chk("lat_runs_complete", (k < 6 * NS), 1);
        repeat (5) step();
        chk("lat1_xfers",    gen_dut[1].n_deliv, NS);
        chk("lat1_done_cnt", gen_dut[1].n_done, 1);
        chk("lat1_sb_empty", gen_dut[1].sb_left, 0);
        chk("lat1_first_lat", gen_dut[1].first_vld - gen_dut[1].first_enb, 2);
        chk("lat4_xfers",    gen_dut[2].n_deliv, NS);
        chk("lat4_done_cnt", gen_dut[2].n_done, 1);
        chk("lat4_sb_empty", gen_dut[2].sb_left, 0);
        chk("lat4_first_lat", gen_dut[2].first_vld - gen_dut[2].first_enb, 5);
        chk("pp_occ4_seen",  gen_dut[2].seen_pp4, 1);
        rdy_pct[1] = 0;
        rdy_pct[2] = 0;

        // Abort mid-fetch once 100 counts have been delivered.
        wr_cnt_a[0] = (AW+1)'(NS);
        rdy_pct[0]  = 100;
        start_a[0]  = 1'b1;
        step();
        start_a[0]  = 1'b0;
        k = 0;
        while (gen_dut[0].n_deliv < 100 && k < 1000) begin
            step();
            k++;
        end
        chk("abort_reached_100", gen_dut[0].n_deliv, 100);
        chk("abort_busy",        gen_dut[0].busy, 1);
        chk("abort_mid_fetch",   (gen_dut[0].n_issued < NS), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_enb",   gen_dut[0].enb, 0);
        chk("abort_addrb", gen_dut[0].addrb, 0);
        chk("abort_vld",   gen_dut[0].vld, 0);
        chk("abort_data",  gen_dut[0].num_node, 0);
        chk("abort_busy0", gen_dut[0].busy, 0);
        chk("abort_done",  gen_dut[0].done, 0);
        step(); step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("abort_no_done",   gen_dut[0].n_done, 0);
        chk("abort_idle",      gen_dut[0].busy, 0);
        start_a[0] = 1'b1;
        step();
        start_a[0] = 1'b0;
        wait_idle0(3 * NS);
        repeat (5) step();
        chk("replay_xfers",    gen_dut[0].n_deliv, NS);
        chk("replay_done_cnt", gen_dut[0].n_done, 1);
        chk("replay_sb_empty", gen_dut[0].sb_left, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/num_node_reader.md
Name: num_node_reader

Overview:
- Downstream stage of the per-subgraph node-count writer in the SPMM path.
- Reads node counts back from port B of the num_node BRAM in subgraph order, hiding BRAM read latency.
- Buffers counts in a small first-word-fall-through FIFO.
- Presents one count per subgraph to the DMVM/softmax/aggregator control over a valid/ready handshake.
- Never reads an address the writer has not yet committed.

Parameters:
- NUM_NODE_WIDTH, 8, width of one node count ($clog2(MAX_NODES), MAX_NODES=168).
- NUM_SUBGRAPHS, 2708, total counts to deliver per run.
- NUM_NODE_ADDR_W, 12, BRAM address width ($clog2(NUM_SUBGRAPHS)).
- BRAM_LAT, 2, cycles from enb/addrb to valid doutb; legal range 1..4.
- FIFO_DEPTH, 4, output buffer entries; power of two, at least BRAM_LAT+1.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- start_i, input, 1, one-cycle pulse that begins a run.
- wr_cnt_i, input, NUM_NODE_ADDR_W+1, number of entries the writer has committed (its address pointer, zero-extended).
- num_node_bram_enb, output, 1, BRAM port-B read enable.
- num_node_bram_addrb, output, NUM_NODE_ADDR_W, BRAM port-B read address.
- num_node_bram_doutb, input, NUM_NODE_WIDTH, BRAM port-B read data.
- num_node_o, output, NUM_NODE_WIDTH, FIFO head count.
- num_node_vld_o, output, 1, num_node_o is valid.
- num_node_rdy_i, input, 1, consumer accepts; a transfer occurs when vld and rdy are both high.
- busy_o, output, 1, run in progress.
- done_o, output, 1, one-cycle pulse after the last count is transferred.

Behaviour:
- Reset (async, rst_n low): all of the following clear to 0 immediately; FSM goes to IDLE.
  - Outputs: enb, addrb, num_node_o, vld, busy_o, done_o.
  - Internal: rd_addr, in-flight counter, latency shift register, FIFO pointers and count, delivered counter.
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE: waits for start_i, then goes to FETCH with rd_addr=0 and delivered=0. busy_o=1 in every state except IDLE.
  - FETCH: issues reads; goes to DRAIN the cycle after the read of address NUM_SUBGRAPHS-1 is issued.
  - DRAIN: no new reads; goes to DONE when delivered reaches NUM_SUBGRAPHS.
  - DONE: asserts done_o for exactly one cycle, then returns to IDLE.
- start_i is ignored outside IDLE.
- Read issue in FETCH: enb=1 and addrb=rd_addr in the same cycle, and rd_addr increments, only when all of these hold:
  - rd_addr < wr_cnt_i.
  - rd_addr < NUM_SUBGRAPHS.
  - in_flight + fifo_count < FIFO_DEPTH (credit check).
- enb and addrb are combinational from registered state; addrb holds its last value when enb=0.
- Return path:
  - A BRAM_LAT-deep valid shift register tracks issued reads.
  - Its output pushes doutb into the FIFO.
  - in_flight increments on issue and decrements on push; a simultaneous issue and push leaves it unchanged.
- FIFO:
  - First-word fall-through: num_node_o = head entry; vld = (fifo_count != 0).
  - Simultaneous push and pop in the same cycle keeps the count, including when full or holding 1 entry.
  - A push into an empty FIFO makes vld high on the next cycle. There is no bypass, so minimum latency from issue to vld is BRAM_LAT+1 cycles.
  - The credit check guarantees no overflow; pop with vld=0 is a no-op.
- num_node_o is stable while vld=1 and rdy=0.
- delivered increments on each handshake; counts are delivered in strictly increasing address order with none dropped or duplicated.
- wr_cnt_i is monotonic within a run; the reader stalls indefinitely while rd_addr == wr_cnt_i.
- Reset mid-run aborts immediately; no done_o is produced for the aborted run.

Test Plan:
- Full run, writer pre-filled: BRAM[i] = i mod 168, wr_cnt_i = 2708, rdy tied high, start pulse.
  - Required: 2708 transfers with values 0,1,…,167,0,…; first vld exactly BRAM_LAT+1 = 3 cycles after the first enb.
  - Required: done_o pulses once, one cycle after the last transfer; busy_o falls the cycle after that.
- Writer throttling: wr_cnt_i starts at 0 and increments by 1 every 5 cycles.
  - Required: enb never asserted with addrb >= wr_cnt_i; all values delivered in order.
- Backpressure: rdy=0 for 20 cycles after start.
  - Required: exactly FIFO_DEPTH = 4 reads issued, fifo_count = 4, num_node_o holds BRAM[0].
  - Required: after rdy rises, transfers proceed at 1 per cycle.
- Random rdy (50%) with BRAM_LAT = 1 and BRAM_LAT = 4: scoreboard shows in-order, lossless delivery and no FIFO overflow.
- Simultaneous push/pop with the FIFO holding 1 and 4 entries: count unchanged, head advances correctly.
- Reset asserted mid-FETCH at delivered = 100.
  - Required: all outputs 0 asynchronously; no done_o; a new start replays from address 0.
